// File: rtl/mirror_display_pkg.sv
// Shared constants for the mirror display sequencer.
// Holds the default geometry (channel word width, channel count, dwell time)
// and the fixed meaning of the first four channel slots as wired from the
// vehicle-data registers.
package mirror_display_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CHANNELS     = 4;
    localparam int DEF_DWELL_CYCLES = 50_000_000;

    // Channel slot assignment of the vehicle-data words
    localparam int CH_TEMP      = 0;
    localparam int CH_AVG_MPG   = 1;
    localparam int CH_INST_MPG  = 2;
    localparam int CH_MILES_REM = 3;

endpackage

// File: rtl/mds_next_chan.sv
// Rotate-priority search for the next enabled display channel.
// Scans sel+1, sel+2, ... (wrapping modulo CHANNELS) and returns the first
// enabled index. When no other channel is enabled the current index is
// returned unchanged.
// Ports:
//   sel      - currently displayed channel index
//   chan_en  - per-channel enable mask
//   next_idx - first enabled channel after sel in rotation order, else sel
//   any_en   - at least one channel is enabled
module mds_next_chan #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [SEL_W-1:0]    next_idx,
    output logic                any_en
);

    always_comb begin
        int  j;
        logic found;
        next_idx = sel;
        found    = 1'b0;
        j        = 0;
        // k starts at 1 so sel itself is never chosen by the scan; it only
        // survives through the default above.
        for (int k = 1; k < CHANNELS; k++) begin
            j = int'(sel) + k;
            if (j >= CHANNELS) begin
                j = j - CHANNELS;
            end
            if (!found && chan_en[j]) begin
                next_idx = SEL_W'(j);
                found    = 1'b1;
            end
        end
        any_en = |chan_en;
    end

endmodule

// File: rtl/mirror_display_sequencer.sv
// Mirror display channel sequencer.
// Selects one of CHANNELS vehicle-data words for the mirror display and
// registers it. The shown channel advances on a debounced button press or,
// in auto mode, when the dwell timer expires. Disabled channels are skipped
// and a channel disabled while shown is left on the next cycle. Freeze holds
// display, selection and timer; presses seen during freeze are dropped.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   data_in       - packed channel words, channel i at [i*WIDTH +: WIDTH]
//   chan_en       - per-channel enable mask
//   mode_auto     - 1 = timer rotation, 0 = manual only
//   next_btn      - debounced advance button (level)
//   freeze        - hold everything
//   display       - registered word of the selected channel
//   sel           - index of the displayed channel
//   display_valid - displayed channel is enabled
//   sel_changed   - one-cycle pulse when sel takes a new value
module mirror_display_sequencer
    import mirror_display_pkg::*;
#(
    parameter  int WIDTH        = DEF_WIDTH,
    parameter  int CHANNELS     = DEF_CHANNELS,
    parameter  int DWELL_CYCLES = DEF_DWELL_CYCLES,
    localparam int SEL_W        = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       chan_en,
    input  logic                      mode_auto,
    input  logic                      next_btn,
    input  logic                      freeze,
    output logic [WIDTH-1:0]          display,
    output logic [SEL_W-1:0]          sel,
    output logic                      display_valid,
    output logic                      sel_changed
);

    localparam int              DW_W       = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    logic [SEL_W-1:0] next_idx;
    logic [SEL_W-1:0] sel_nxt;
    logic             any_en;
    logic [DW_W-1:0]  dwell_q;
    logic [DW_W-1:0]  dwell_nxt;
    logic             btn_q;
    logic             mode_q;
    logic             press;
    logic             expire;
    logic             advance;
    logic [WIDTH-1:0] word_nxt;
    logic             valid_nxt;

    mds_next_chan #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next_chan (
        .sel      (sel),
        .chan_en  (chan_en),
        .next_idx (next_idx),
        .any_en   (any_en)
    );

    always_comb begin
        press   = next_btn & ~btn_q;
        expire  = mode_auto && (dwell_q == DWELL_LAST);
        // Press, expiry and forced skip all collapse into one advance.
        advance = !freeze && (press || expire || !chan_en[sel]);
        sel_nxt = advance ? next_idx : sel;

        dwell_nxt = dwell_q;
        if (!freeze) begin
            if (advance || !mode_auto || (mode_auto != mode_q)) begin
                dwell_nxt = '0;
            end else begin
                // Cannot pass DWELL_LAST: reaching it in auto mode advances.
                dwell_nxt = dwell_q + 1'b1;
            end
        end

        // Look up the word of the sel value being registered this cycle so
        // display and sel always refer to the same channel.
        word_nxt  = data_in[sel_nxt*WIDTH +: WIDTH];
        valid_nxt = any_en && chan_en[sel_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel           <= '0;
            display       <= '0;
            display_valid <= 1'b0;
            sel_changed   <= 1'b0;
            dwell_q       <= '0;
            btn_q         <= 1'b0;
            // Track the mode through reset so release does not look like a
            // mode change and shorten or stretch the first dwell.
            mode_q        <= mode_auto;
        end else begin
            btn_q   <= next_btn;
            mode_q  <= mode_auto;
            dwell_q <= dwell_nxt;
            if (!freeze) begin
                sel           <= sel_nxt;
                display       <= word_nxt;
                display_valid <= valid_nxt;
                sel_changed   <= (sel_nxt != sel);
            end else begin
                sel_changed   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mirror_display_sequencer.sv
module tb_mirror_display_sequencer;
    import mirror_display_pkg::*;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int DWELL    = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       chan_en;
    logic                      mode_auto;
    logic                      next_btn;
    logic                      freeze;
    logic [WIDTH-1:0]          display;
    logic [1:0]                sel;
    logic                      display_valid;
    logic                      sel_changed;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] disp_tab [4];
    logic [1:0]       exp_q [$];

    mirror_display_sequencer #(
        .WIDTH        (WIDTH),
        .CHANNELS     (CHANNELS),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .chan_en       (chan_en),
        .mode_auto     (mode_auto),
        .next_btn      (next_btn),
        .freeze        (freeze),
        .display       (display),
        .sel           (sel),
        .display_valid (display_valid),
        .sel_changed   (sel_changed)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance one rising edge; outputs are stable 1ns afterwards and inputs
    // are changed there, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] c3, input logic [7:0] c2,
                            input logic [7:0] c1, input logic [7:0] c0);
        data_in = {c3, c2, c1, c0};
    endtask

    task automatic press_once();
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
        tick();
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int pulses;
        disp_tab[0] = 8'd72;
        disp_tab[1] = 8'd25;
        disp_tab[2] = 8'd30;
        disp_tab[3] = 8'd40;

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        chan_en   = 4'b1111;
        mode_auto = 1'b1;
        next_btn  = 1'b0;
        freeze    = 1'b0;
        data_in   = {$urandom, $urandom} >> 32;
        for (int i = 0; i < 3; i++) begin
            data_in = CHANNELS*WIDTH'($urandom);
            tick();
        end
        check("rst_display", display, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", display_valid, 0);
        check("rst_changed", sel_changed, 0);

        set_data(8'd40, 8'd30, 8'd25, 8'd72);
        rst_n = 1'b1;
        tick();
        check("rel_display", display, 72);
        check("rel_valid", display_valid, 1);
        check("rel_sel", sel, 0);

        // ---------------- auto rotation, 4-cycle dwell ----------------
        for (int c = 2; c <= 16; c++) begin
            exp_q.push_back(2'((c / 4) % 4));
        end
        for (int c = 2; c <= 16; c++) begin
            logic [1:0] es;
            tick();
            es = exp_q.pop_front();
            check($sformatf("auto_sel_c%0d", c), sel, es);
            check($sformatf("auto_disp_c%0d", c), display, disp_tab[es]);
            check($sformatf("auto_chg_c%0d", c), sel_changed, (c % 4 == 0));
        end

        // ---------------- skip disabled channels, manual ----------------
        mode_auto = 1'b0;
        chan_en   = 4'b1011;
        tick();
        check("skip_start", sel, 0);
        next_btn = 1'b1;
        tick();
        check("skip_p1_sel", sel, 1);
        check("skip_p1_chg", sel_changed, 1);
        next_btn = 1'b0;
        tick();
        check("skip_p1_chg_off", sel_changed, 0);
        press_once();
        check("skip_p2_sel", sel, 3);
        check("skip_p2_disp", display, 40);
        check("skip_p2_valid", display_valid, 1);
        press_once();
        check("skip_p3_sel", sel, 0);
        press_once();
        press_once();
        check("skip_back3", sel, 3);
        chan_en = 4'b0011;
        tick();
        check("forced_skip_sel", sel, 0);
        check("forced_skip_chg", sel_changed, 1);
        check("forced_skip_valid", display_valid, 1);

        // ---------------- held button ----------------
        chan_en  = 4'b1111;
        next_btn = 1'b1;
        pulses   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sel_changed) pulses++;
        end
        check("held_pulses", pulses, 1);
        check("held_sel", sel, 1);
        next_btn = 1'b0;
        tick();

        // ---------------- press coincident with expiry ----------------
        mode_auto = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("coin_pre%0d", i), sel, 1);
        end
        next_btn = 1'b1;
        tick();
        check("coin_sel", sel, 2);
        check("coin_chg", sel_changed, 1);
        next_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("coin_dwell%0d", i), sel, 2);
        end
        tick();
        check("coin_next_step", sel, 3);

        mode_auto = 1'b0;
        tick();
        check("manual_hold", sel, 3);
        press_once();
        press_once();
        press_once();
        check("to_ch2_sel", sel, 2);
        check("to_ch2_disp", display, 30);

        // ---------------- freeze ----------------
        freeze   = 1'b1;
        set_data(8'd40, 8'd99, 8'd25, 8'd72);
        next_btn = 1'b1;
        tick();
        tick();
        check("frz_disp", display, 30);
        check("frz_sel", sel, 2);
        check("frz_chg", sel_changed, 0);
        freeze = 1'b0;
        tick();
        check("unfrz_disp", display, 99);
        check("unfrz_sel", sel, 2);
        next_btn = 1'b0;
        tick();
        check("unfrz_no_late", sel, 2);

        // ---------------- all disabled ----------------
        chan_en = 4'b0000;
        tick();
        check("none_valid", display_valid, 0);
        check("none_sel", sel, 2);
        set_data(8'd40, 8'd55, 8'd25, 8'd72);
        tick();
        check("none_track", display, 55);
        check("none_chg", sel_changed, 0);

        // ---------------- reset mid-dwell ----------------
        chan_en   = 4'b1111;
        mode_auto = 1'b1;
        tick();
        tick();
        tick();
        check("mid_pre_sel", sel, 2);
        rst_n = 1'b0;
        tick();
        check("mid_rst_sel", sel, 0);
        check("mid_rst_disp", display, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_dwell%0d", i), sel, 0);
        end
        check("mid_disp", display, 72);
        tick();
        check("mid_step_sel", sel, 1);
        check("mid_step_disp", display, 25);
        check("mid_step_chg", sel_changed, 1);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
